// File: rtl/adder_sequencer.sv
// Initiator-side sequencer for one neuron potential adder: turns config writes into
// load edges and step requests into a time_step/done handshake. Optional macro: SPIKE_COUNT_EN.
module adder_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  input  logic [2:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  output logic        cfg_ready,
  input  logic        step_valid,
  input  logic [31:0] step_weight,
  input  logic [31:0] step_decayed,
  output logic        step_ready,
  output logic [31:0] adder_weight,
  output logic [31:0] adder_decayed,
  output logic [2:0]  adder_init_mode,
  output logic        adder_load,
  output logic        adder_time_step,
  input  logic        adder_done,
  input  logic        adder_spike,
  input  logic [31:0] adder_potential,
  output logic        res_valid,
  output logic [31:0] res_potential,
  output logic        res_spike,
  output logic        timeout_err,
  output logic [15:0] spike_count,
  input  logic        cnt_clr
);

  // Shared init_mode codes: DEFAULT=0, A=1, B=2, C=3, D=4, VT=5, U=6.
  localparam logic [2:0] MODE_DEFAULT = 3'd0;

  // Wait counter only has to hold 0 .. TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_SETUP, S_CFG_LOAD, S_CFG_HOLD,
    S_STEP_SETUP, S_STEP_PULSE, S_STEP_ARM, S_STEP_WAIT
  } state_t;

  state_t        r_state;
  logic [2:0]    r_mode;
  logic [31:0]   r_weight;
  logic [31:0]   r_decayed;
  logic          r_load;
  logic          r_time_step;
  logic          r_arm;
  logic [CW-1:0] r_tmo;
  logic          r_res_valid;
  logic [31:0]   r_res_potential;
  logic          r_res_spike;
  logic          r_timeout_err;
  logic          w_idle;

  assign w_idle     = (r_state == S_IDLE);
  assign cfg_ready  = w_idle;
  assign step_ready = w_idle && !cfg_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_mode          <= MODE_DEFAULT;
      r_weight        <= '0;
      r_decayed       <= '0;
      r_load          <= 1'b0;
      r_time_step     <= 1'b0;
      r_arm           <= 1'b0;
      r_tmo           <= '0;
      r_res_valid     <= 1'b0;
      r_res_potential <= '0;
      r_res_spike     <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_load      <= 1'b0;
      r_time_step <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_mode   <= cfg_sel;
            r_weight <= cfg_data;
            r_state  <= S_CFG_SETUP;
          end else if (step_valid) begin
            r_mode    <= MODE_DEFAULT;
            r_weight  <= step_weight;
            r_decayed <= step_decayed;
            r_state   <= S_STEP_SETUP;
          end
        end
        S_CFG_SETUP: begin
          r_load  <= 1'b1;
          r_state <= S_CFG_LOAD;
        end
        S_CFG_LOAD: r_state <= S_CFG_HOLD;
        S_CFG_HOLD: begin
          r_mode  <= MODE_DEFAULT;
          r_state <= S_IDLE;
        end
        S_STEP_SETUP: begin
          r_time_step <= 1'b1;
          r_state     <= S_STEP_PULSE;
        end
        S_STEP_PULSE: begin
          r_arm   <= 1'b0;
          r_state <= S_STEP_ARM;
        end
        // done is stale from the previous step until the adder sees the edge
        S_STEP_ARM: begin
          if (r_arm) begin
            r_tmo   <= '0;
            r_state <= S_STEP_WAIT;
          end else begin
            r_arm <= 1'b1;
          end
        end
        S_STEP_WAIT: begin
          if (adder_done) begin
            r_res_potential <= adder_potential;
            r_res_spike     <= adder_spike;
            r_res_valid     <= 1'b1;
            r_state         <= S_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adder_weight    = r_weight;
  assign adder_decayed   = r_decayed;
  assign adder_init_mode = r_mode;
  assign adder_load      = r_load;
  assign adder_time_step = r_time_step;
  assign res_valid       = r_res_valid;
  assign res_potential   = r_res_potential;
  assign res_spike       = r_res_spike;
  assign timeout_err     = r_timeout_err;

`ifdef SPIKE_COUNT_EN
  logic [15:0] r_spike_cnt;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      r_spike_cnt <= '0;
    else if (r_res_valid && r_res_spike && (r_spike_cnt != 16'hFFFF))
      r_spike_cnt <= r_spike_cnt + 16'd1;
  end

  assign spike_count = r_spike_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign spike_count      = '0;
`endif

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: directed and randomized config/step traffic against a
// behavioural LIF adder and a cycle-count reference for the handshake timing.
module tb_adder_sequencer;
  localparam int TMO = 8;
  localparam logic [2:0] M_DEF = 3'd0;
  localparam logic [2:0] M_A   = 3'd1;
  localparam logic [2:0] M_VT  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready;
  logic        step_valid = 1'b0;
  logic [31:0] step_weight = '0;
  logic [31:0] step_decayed = '0;
  logic        step_ready;
  logic [31:0] adder_weight, adder_decayed;
  logic [2:0]  adder_init_mode;
  logic        adder_load, adder_time_step;
  logic        adder_done = 1'b0;
  logic        adder_spike = 1'b0;
  logic [31:0] adder_potential = '0;
  logic        res_valid;
  logic [31:0] res_potential;
  logic        res_spike;
  logic        timeout_err;
  logic [15:0] spike_count;
  logic        cnt_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] vt_ref = '0;
  int spk_ref = 0;

  adder_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .step_valid(step_valid), .step_weight(step_weight), .step_decayed(step_decayed),
    .step_ready(step_ready),
    .adder_weight(adder_weight), .adder_decayed(adder_decayed),
    .adder_init_mode(adder_init_mode), .adder_load(adder_load),
    .adder_time_step(adder_time_step), .adder_done(adder_done),
    .adder_spike(adder_spike), .adder_potential(adder_potential),
    .res_valid(res_valid), .res_potential(res_potential), .res_spike(res_spike),
    .timeout_err(timeout_err), .spike_count(spike_count), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Behavioural LIF adder: VT latched on a load rising edge; on a time_step rising
  // edge done drops, and one cycle later potential/spike are produced and done rises.
  logic [31:0] a_vt = '0;
  logic        a_load_d = 1'b0, a_ts_d = 1'b0, a_pend = 1'b0, a_hold = 1'b0;
  logic [31:0] a_sum;
  always @(posedge clk) begin
    a_load_d <= adder_load;
    a_ts_d   <= adder_time_step;
    if (adder_load && !a_load_d && adder_init_mode == M_VT) a_vt <= adder_weight;
    if (a_hold) begin
      adder_done <= 1'b0;
      a_pend     <= 1'b0;
    end else if (adder_time_step && !a_ts_d) begin
      adder_done <= 1'b0;
      a_pend     <= 1'b1;
    end else if (a_pend) begin
      a_pend = 1'b0;
      a_sum  = adder_weight + adder_decayed;
      adder_done  <= 1'b1;
      adder_spike <= (a_sum >= a_vt);
      adder_potential <= (a_sum >= a_vt) ? a_sum - a_vt : a_sum;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef SPIKE_COUNT_EN
    return spk_ref;
`else
    return 0;
`endif
  endfunction

  // Called at the negedge of the handshake cycle T with cfg inputs already driven.
  task automatic cfg_tail(input logic [2:0] sel, input logic [31:0] data);
    @(negedge clk); cfg_valid = 1'b0;
    chk("cfg_setup_load", adder_load, 0);
    chk("cfg_setup_mode", adder_init_mode, sel);
    chk("cfg_setup_data", adder_weight, data);
    chk("cfg_busy", cfg_ready, 0);
    @(negedge clk);
    chk("cfg_load_hi", adder_load, 1);
    chk("cfg_load_mode", adder_init_mode, sel);
    chk("cfg_load_data", adder_weight, data);
    @(negedge clk);
    chk("cfg_hold_load", adder_load, 0);
    chk("cfg_hold_mode", adder_init_mode, sel);
    @(negedge clk);
    chk("cfg_mode_default", adder_init_mode, M_DEF);
    chk("cfg_ready_again", cfg_ready, 1);
    if (sel == M_VT) vt_ref = data;
  endtask

  task automatic do_cfg(input logic [2:0] sel, input logic [31:0] data);
    @(negedge clk);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_data = data;
    cfg_tail(sel, data);
  endtask

  // Called at the negedge of the handshake cycle T with step inputs already driven.
  task automatic step_tail(input logic [31:0] w, input logic [31:0] d, input logic clr);
    logic [31:0] s, e_pot;
    logic e_spk;
    s = w + d;
    e_spk = (s >= vt_ref);
    e_pot = e_spk ? s - vt_ref : s;
    @(negedge clk); step_valid = 1'b0;
    chk("step_setup_ts", adder_time_step, 0);
    chk("step_setup_w", adder_weight, w);
    chk("step_setup_d", adder_decayed, d);
    chk("step_setup_mode", adder_init_mode, M_DEF);
    chk("step_busy", step_ready, 0);
    @(negedge clk);
    chk("step_pulse_ts", adder_time_step, 1);
    chk("step_pulse_rv", res_valid, 0);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk("step_arm_ts", adder_time_step, 0);
      chk("step_early_rv", res_valid, 0);
      chk("step_hold_w", adder_weight, w);
      chk("step_hold_d", adder_decayed, d);
    end
    @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_potential", res_potential, e_pot);
    chk("res_spike", res_spike, e_spk);
    chk("ready_after_res", step_ready, 1);
    cnt_clr = clr;
    if (clr) spk_ref = 0;
    else if (e_spk && spk_ref < 65535) spk_ref++;
    @(negedge clk); cnt_clr = 1'b0;
    chk("res_valid_1cyc", res_valid, 0);
    chk("res_pot_held", res_potential, e_pot);
    chk("spike_count", spike_count, cnt_exp());
  endtask

  task automatic do_step(input logic [31:0] w, input logic [31:0] d, input logic clr);
    @(negedge clk);
    chk("step_ready_idle", step_ready, 1);
    step_valid = 1'b1; step_weight = w; step_decayed = d;
    step_tail(w, d, clr);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_step_ready", step_ready, 1);
    chk("rst_load", adder_load, 0);
    chk("rst_ts", adder_time_step, 0);
    chk("rst_mode", adder_init_mode, M_DEF);
    chk("rst_weight", adder_weight, 0);
    chk("rst_decayed", adder_decayed, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_pot", res_potential, 0);
    chk("rst_res_spike", res_spike, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_cnt", spike_count, 0);
    rst = 1'b0;

    // VT=100, then the LIF reference step
    do_cfg(M_VT, 100);
    do_step(60, 50, 1'b0);
    do_step(20, 30, 1'b0);

    // cfg and step together: config first, step taken at T+4
    @(negedge clk);
    cfg_valid = 1'b1; cfg_sel = M_VT; cfg_data = 120;
    step_valid = 1'b1; step_weight = 90; step_decayed = 40;
    #1 chk("simul_step_blocked", step_ready, 0);
    cfg_tail(M_VT, 120);
    chk("simul_step_ready_t4", step_ready, 1);
    step_tail(90, 40, 1'b0);

    // Adder stuck: abort after TMO cycles in STEP_WAIT, no result
    a_hold = 1'b1;
    @(negedge clk);
    step_valid = 1'b1; step_weight = 1; step_decayed = 2;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) step_valid = 1'b0;
      chk("tmo_no_res", res_valid, 0);
      chk("tmo_err", timeout_err, (k >= 13) ? 1 : 0);
      if (k == 12) chk("tmo_busy", cfg_ready, 0);
      if (k == 13) chk("tmo_idle", cfg_ready, 1);
    end
    a_hold = 1'b0;
    do_step(100, 30, 1'b0);
    chk("tmo_sticky", timeout_err, 1);

    // Reset during STEP_ARM
    @(negedge clk);
    step_valid = 1'b1; step_weight = 200; step_decayed = 5;
    @(negedge clk); step_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    spk_ref = 0;
    chk("arm_rst_ts", adder_time_step, 0);
    chk("arm_rst_ready", cfg_ready, 1);
    chk("arm_rst_sready", step_ready, 1);
    chk("arm_rst_tmo", timeout_err, 0);
    chk("arm_rst_cnt", spike_count, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arm_rst_no_res", res_valid, 0);
    end

    // Randomized traffic; non-VT writes must not disturb the threshold
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0: do_cfg(M_VT, 32'($urandom_range(50, 150)));
        1: do_cfg(M_A, $urandom);
        default: ;
      endcase
      do_step(32'($urandom_range(0, 120)), 32'($urandom_range(0, 120)), 1'b0);
    end

    // Three spikes, then clear concurrent with a fourth
    for (int n = 0; n < 3; n++) do_step(vt_ref, 32'(n + 1), 1'b0);
    do_step(vt_ref, 7, 1'b1);
    chk("cnt_clr_wins", spike_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
